// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - result FIFO, register-file write port and pending-destination scoreboard
module writeback_unit #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  aluValid,
   input  logic [4:0]            aluRd,
   input  logic [DATA_WIDTH-1:0] aluData,
   input  logic                  memValid,
   input  logic [4:0]            memRd,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic                  inReady,
   input  logic                  issueValid,
   input  logic [4:0]            issueRd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic                  hazardRd,
   output logic                  regWrite,
   output logic [4:0]            writeRegId,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]            rd_mem_q   [DEPTH];
   logic [4:0]            rd_mem_d   [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  reg_write_q, reg_write_d;
   logic [4:0]            write_reg_id_q, write_reg_id_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic                  overflow_q, overflow_d;
   logic [31:0]           pending_q, pending_d;

   logic                  push_alu, push_mem, pop;
   logic                  accept_alu, accept_mem;
   logic [CNT_W:0]        free_slots;
   logic [PTR_W-1:0]      mem_slot;

   // Admission: a slot vacated by this edge's pop can be refilled on the same edge.
   always_comb begin
      push_alu   = aluValid && (aluRd != 5'd0);
      push_mem   = memValid && (memRd != 5'd0);
      pop        = (count_q != '0);
      free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
      accept_alu = push_alu && (free_slots >= (CNT_W+1)'(1));
      accept_mem = push_mem && (free_slots >= (accept_alu ? (CNT_W+1)'(2) : (CNT_W+1)'(1)));
      mem_slot   = accept_alu ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
   end

   // FIFO storage, pointers, occupancy and the sticky drop flag.
   always_comb begin
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      if (accept_alu) begin
         rd_mem_d[wr_ptr_q]   = aluRd;
         data_mem_d[wr_ptr_q] = aluData;
      end
      if (accept_mem) begin
         rd_mem_d[mem_slot]   = memRd;
         data_mem_d[mem_slot] = memData;
      end
      wr_ptr_d   = wr_ptr_q + PTR_W'(accept_alu) + PTR_W'(accept_mem);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      count_d    = count_q + CNT_W'(accept_alu) + CNT_W'(accept_mem) - CNT_W'(pop);
      overflow_d = overflow_q || (push_alu && !accept_alu) || (push_mem && !accept_mem);
   end

   // Register-file write port: pop the head each edge, hold address/data when idle.
   always_comb begin
      reg_write_d    = pop;
      write_reg_id_d = write_reg_id_q;
      write_data_d   = write_data_q;
      if (pop) begin
         write_reg_id_d = rd_mem_q[rd_ptr_q];
         write_data_d   = data_mem_q[rd_ptr_q];
      end
   end

   // Scoreboard: clear on commit, then set on issue so a same-edge set wins.
   always_comb begin
      pending_d = pending_q;
      if (reg_write_q) begin
         pending_d[write_reg_id_q] = 1'b0;
      end
      if (issueValid && (issueRd != 5'd0)) begin
         pending_d[issueRd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         reg_write_q    <= 1'b0;
         write_reg_id_q <= '0;
         write_data_q   <= '0;
         overflow_q     <= 1'b0;
         pending_q      <= '0;
      end else begin
         rd_mem_q       <= rd_mem_d;
         data_mem_q     <= data_mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         reg_write_q    <= reg_write_d;
         write_reg_id_q <= write_reg_id_d;
         write_data_q   <= write_data_d;
         overflow_q     <= overflow_d;
         pending_q      <= pending_d;
      end
   end

   assign inReady    = (count_q <= CNT_W'(DEPTH - 2));
   assign hazard1    = pending_q[rs1];
   assign hazard2    = pending_q[rs2];
   assign hazardRd   = pending_q[issueRd];
   assign regWrite   = reg_write_q;
   assign writeRegId = write_reg_id_q;
   assign writeData  = write_data_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage feeding the register file's write port (regWrite / writeRegId / writeData). Collects results from the single-cycle ALU path and the multi-cycle load path, buffers them in a small FIFO, and retires at most one register write per clock. Holds a per-register pending scoreboard so decode can stall on RAW/WAW hazards against in-flight destinations.

## Interface

- DEPTH, 4: FIFO entries; power of two, ≥ 2
- DATA_WIDTH, 32: result width; matches register file data width
- clock  in  1  rising-edge clock, shared with the register file
- resetN  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result present this cycle
- aluRd  in  5  ALU destination register
- aluData  in  DATA_WIDTH  ALU result
- memValid  in  1  load result present this cycle
- memRd  in  5  load destination register
- memData  in  DATA_WIDTH  load result
- inReady  out  1  both result ports may be presented this cycle
- issueValid  in  1  decode issues an instruction writing issueRd
- issueRd  in  5  destination of issuing instruction
- rs1, rs2  in  5 each  source registers of instruction in decode
- hazard1, hazard2, hazardRd  out  1 each  combinational: rs1 / rs2 / issueRd pending
- regWrite  out  1  register-file write enable (registered)
- writeRegId  out  5  register-file write address (registered)
- writeData  out  DATA_WIDTH  register-file write data (registered)
- overflow  out  1  sticky: a result was dropped due to full FIFO

## Operation

- Clock is single; reset asynchronous, active-low.
- FIFO: circular buffer, DEPTH entries of {rd, data}; read/write pointers log2(DEPTH) bits, wrap naturally; occupancy counter 0..DEPTH.
- inReady = (count ≤ DEPTH−2); guarantees room for two pushes in one edge.
- Enqueue at rising edge: each valid port with rd ≠ 0 pushes one entry. Both valid: ALU entry first, load entry second. rd = 0 results discarded (no push, no scoreboard effect).
- Push when no free slot: that entry dropped, overflow set, held until reset. Partial case (one slot, two pushes): ALU kept, load dropped.
- Drain: each edge, if count > 0 before the edge, head popped into writeRegId/writeData and regWrite = 1; else regWrite = 0, writeRegId/writeData hold previous values. Push and pop on same edge allowed; count updates by pushes − pop.
- Scoreboard: pending[31:1] bits, pending[0] constant 0.
  - Set: edge with issueValid and issueRd ≠ 0.
  - Clear: edge on which regWrite = 1 (write committing into register file), bit writeRegId.
  - Same register set and cleared on same edge: ends pending = 1.
- hazard1 = pending[rs1], hazard2 = pending[rs2], hazardRd = pending[issueRd]; decode must not issue while hazardRd = 1 (WAW); block does not police this.
- Data arriving for a non-pending rd still written normally.

## Timing

- Reset (resetN low, any time): count = 0, pointers = 0, regWrite = 0, writeRegId = 0, writeData = 0, pending = 0, overflow = 0; takes effect immediately, in-flight entries lost.
- Latency, empty FIFO: result accepted at edge N → regWrite = 1 during cycle after edge N+1 → register file writes at edge N+2; pending bit clears at edge N+2, hazard flags fall in cycle after N+2.
- Throughput: one write per cycle sustained; dual-port bursts absorbed by FIFO.
- inReady, hazard flags: combinational from current state (and rs1/rs2/issueRd), no dependency on valid inputs.
- Deassertion of resetN: first active edge is the next rising edge.

## Test plan

- Reset then aluValid, aluRd=5, aluData=50 at edge 1 → regWrite=1, writeRegId=5, writeData=50 in cycle after edge 2; regWrite=0 next cycle.
- aluValid+memValid same edge, rd 3/data 0x11 and rd 7/data 0x22 → two consecutive writes: (3,0x11) then (7,0x22).
- aluRd=0 with valid, data 0xFF → no regWrite, no scoreboard change, count stays 0.
- issueValid issueRd=9, hold rs1=9 → hazard1=1 until ALU result rd=9 commits (regWrite with writeRegId=9), then 0; hazardRd for 9 mirrors it.
- DEPTH=4: fill with dual pushes 3 cycles while forcing no drain impossible → instead drive pushes each cycle until count=4 reached with 2 pushes/cycle; check inReady=0 at count ≥ 3, extra push drops, overflow=1 and stays 1.
- Assert resetN low while FIFO holds 3 entries → regWrite=0, count=0, pending=0 immediately; no stale writes after release.
